// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU result producers and the register-file write arbiter.
// master: the result producers and the register-file side; slave: the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR  = 5,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [ADDR-1:0]  alu_addr;
  logic [WIDTH-1:0] alu_data;
  logic             alu_stall;

  logic             lsu_valid;
  logic             lsu_ready;
  logic [ADDR-1:0]  lsu_addr;
  logic [WIDTH-1:0] lsu_data;

  logic             write_enable;
  logic [ADDR-1:0]  write_address;
  logic [WIDTH-1:0] write_data;
  logic [CW-1:0]    fifo_count;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  alu_stall, lsu_ready, write_enable, write_address, write_data, fifo_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output alu_stall, lsu_ready, write_enable, write_address, write_data, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port. ALU results win by
// default; long-latency results queue in a small FIFO and are force-granted (stalling the ALU)
// once the FIFO head has been denied STARVE_LIMIT consecutive cycles.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR         = 5,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned EW = ADDR + WIDTH;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             we_q, we_d;
  logic [ADDR-1:0]  waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             fifo_nonempty;
  logic             force_grant;
  logic             grant_fifo;
  logic             grant_alu;
  logic             push;
  logic             pop;
  logic             lsu_ready;
  logic [EW-1:0]    head;
  logic [ADDR-1:0]  head_addr;
  logic [WIDTH-1:0] head_data;

  assign head      = mem_q[rd_ptr_q];
  assign head_addr = head[EW-1:WIDTH];
  assign head_data = head[WIDTH-1:0];

  // Ready depends on registered occupancy only, so a same-cycle pop never frees a full FIFO.
  assign lsu_ready = (count_q != CW'(DEPTH));

  // Grant decision: forced FIFO grant beats ALU priority, which beats a normal FIFO grant.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    force_grant   = (starve_q == SW'(STARVE_LIMIT)) && fifo_nonempty;
    grant_fifo    = force_grant || (!bus.alu_valid && fifo_nonempty);
    grant_alu     = bus.alu_valid && !force_grant;
    push          = bus.lsu_valid && lsu_ready;
    pop           = grant_fifo;
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.lsu_addr, bus.lsu_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts consecutive cycles a waiting FIFO head loses, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!fifo_nonempty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Output register next state; writes to x0 are consumed but never enabled.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_fifo) begin
      waddr_d = head_addr;
      wdata_d = head_data;
      we_d    = (head_addr != '0);
    end else if (grant_alu) begin
      waddr_d = bus.alu_addr;
      wdata_d = bus.alu_data;
      we_d    = (bus.alu_addr != '0);
    end
  end

  // State update with synchronous reset; FIFO payload needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.alu_stall     = force_grant && bus.alu_valid;
  assign bus.lsu_ready     = lsu_ready;
  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data    = wdata_q;
  assign bus.fifo_count    = count_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback-stage arbiter directly upstream of the register file's single write port.
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results, which take priority;
  - long-latency load/multi-cycle results, buffered in a DEPTH-entry FIFO with valid/ready.
- A starvation counter guarantees forward progress of the buffered path by stalling the ALU.

Parameters:
- ADDR, 5, register address width.
- WIDTH, 32, data width.
- DEPTH, 4, FIFO entries for the long-latency path; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may be denied before a forced grant; at least 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_addr  input  ADDR  ALU destination register.
- alu_data  input  WIDTH  ALU result.
- alu_stall  output  1  combinational; ALU must hold alu_* unchanged next cycle.
- lsu_valid  input  1  long-latency result offered.
- lsu_ready  output  1  FIFO can accept; transfer when lsu_valid and lsu_ready.
- lsu_addr  input  ADDR  long-latency destination register.
- lsu_data  input  WIDTH  long-latency result.
- write_enable  output  1  registered; to register file.
- write_address  output  ADDR  registered; to register file.
- write_data  output  WIDTH  registered; to register file.
- fifo_count  output  $clog2(DEPTH)+1  registered FIFO occupancy.

Behaviour:
- Reset:
  - Synchronous; reset wins over every other event in the same cycle.
  - Clears write_enable, write_address, write_data, fifo_count, FIFO pointers and starve counter to 0.
  - Buffered entries are discarded; no write issues in the cycle after reset.
- FIFO:
  - lsu_ready = (fifo_count != DEPTH), taken from registered state only.
  - When full, lsu_ready is low even if a pop occurs that cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: an entry pushed at edge N is poppable in cycle N+1.
- Grant, each cycle, with force = (starve == STARVE_LIMIT) && fifo_count != 0:
  - force: grant the FIFO head (pop); alu_stall = alu_valid.
  - else if alu_valid: grant the ALU; alu_stall = 0.
  - else if fifo_count != 0: grant the FIFO head (pop).
  - else: no grant.
- Starve counter:
  - Increments when fifo_count != 0 and the FIFO is not granted.
  - Clears when the FIFO is granted or empty.
  - Saturates at STARVE_LIMIT.
- Output register:
  - On a grant, at the next edge: write_address <= granted addr, write_data <= granted data.
  - write_enable <= (granted addr != 0).
  - A grant with addr 0 is consumed (FIFO popped / ALU accepted) but produces write_enable = 0.
  - With no grant, write_enable <= 0; write_address and write_data hold their values.
- Latency:
  - ALU: alu_valid in cycle N gives write_enable in cycle N+1.
  - LSU: handshake in cycle N gives earliest write_enable in cycle N+2 (ALU idle).
- Ordering:
  - FIFO entries retire in push order.
  - No same-address hazard checking between sources; a later write simply overwrites.
- Throughput: at most one write per cycle; one ALU result or one FIFO pop per cycle.

Test Plan:
- Reset then ALU: assert reset 2 cycles, then alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF for 1 cycle.
  - Next cycle: write_enable=1, write_address=5, write_data=0xDEADBEEF.
  - Following cycle: write_enable=0.
- LSU-only latency and order: push (3,0x11), (4,0x22), (7,0x33) on back-to-back cycles with ALU idle.
  - Writes appear in that order, the first 2 cycles after its handshake.
  - fifo_count peaks at 1 and returns to 0.
- Priority and full: alu_valid=1 continuously, push 4 LSU entries.
  - fifo_count=4 and lsu_ready=0; ALU writes every cycle until the force grant.
- Starvation: continue the previous case with STARVE_LIMIT=8.
  - 8 cycles after the first push, alu_stall=1 for one cycle and the oldest LSU entry is written.
  - The held ALU result is written the cycle after.
- x0 drop: ALU addr 0 data 0x55, then LSU addr 0 data 0x66.
  - write_enable stays 0 throughout; the FIFO still pops (fifo_count 1→0).
- Reset mid-operation: with fifo_count=3, assert reset 1 cycle.
  - Next cycle: fifo_count=0, write_enable=0, lsu_ready=1; none of the buffered entries is ever written.
